// File: rtl/avalon_st_pkg.sv
// Shared types and constants for the Avalon-ST packet FIFO.
package avalon_st_pkg;

  localparam int DEFAULT_DATA_BYTES = 8;
  localparam int DEFAULT_EMPTY_W    = $clog2(DEFAULT_DATA_BYTES);

  typedef struct packed {
    logic [DEFAULT_DATA_BYTES*8-1:0] data;
    logic [DEFAULT_EMPTY_W-1:0]      empty;
    logic                            sop;
    logic                            eop;
  } beat_t;

  localparam logic [1:0] CSR_LEVEL   = 2'd0;
  localparam logic [1:0] CSR_PKT_CNT = 2'd1;
  localparam logic [1:0] CSR_ERR_CNT = 2'd2;
  localparam logic [1:0] CSR_CTRL    = 2'd3;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage: array, extra-MSB pointers, full/empty and level,
// with a synchronous clear that empties the FIFO on the next edge.
module sync_fifo_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;

  // Pointer update; callers never push when full or pop when empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r[AW-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/avalon_st_pkt_fifo.sv
// Avalon-ST packet FIFO with SOP/EOP framing checks and a small CSR bus.
// Optional build macro PKT_FIFO_ERR_DROP_EN drops orphan (non-SOP, out-of-packet) beats.
module avalon_st_pkt_fifo
  import avalon_st_pkg::*;
#(
  parameter int DATA_BYTES = DEFAULT_DATA_BYTES,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_BYTES*8-1:0]       in_data,
  input  logic [$clog2(DATA_BYTES)-1:0] in_empty,
  input  logic                          in_valid,
  input  logic                          in_startofpacket,
  input  logic                          in_endofpacket,
  output logic                          in_ready,
  output logic [DATA_BYTES*8-1:0]       out_data,
  output logic [$clog2(DATA_BYTES)-1:0] out_empty,
  output logic                          out_valid,
  output logic                          out_startofpacket,
  output logic                          out_endofpacket,
  input  logic                          out_ready,
  input  logic [1:0]                    csr_address,
  input  logic                          csr_read,
  input  logic                          csr_write,
  input  logic [31:0]                   csr_writedata,
  output logic [31:0]                   csr_readdata,
  output logic                          csr_readdatavalid,
  output logic                          csr_waitrequest
);

  localparam int EW = $clog2(DATA_BYTES);
  localparam int BW = DATA_BYTES*8 + EW + 2;
  localparam int AW = $clog2(DEPTH);

  logic          full_s, empty_s;
  logic [AW:0]   level_s;
  logic [BW-1:0] rbeat_s;
  logic          accept_s, pop_s, wr_en_s, err_s, orphan_s, in_pkt_nxt_s;
  logic          err_clr_s, flush_set_s;
  logic [31:0]   rd_mux_s;
  logic          in_pkt_r, flush_r;
  logic [31:0]   pkt_count_r, err_count_r, readdata_r;
  logic          readdatavalid_r;
  logic          unused_wdata_s;

  assign unused_wdata_s = ^csr_writedata[31:1];

  sync_fifo_core #(.WIDTH(BW), .DEPTH(DEPTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (flush_r),
    .push    (wr_en_s),
    .pop     (pop_s),
    .wdata   ({in_data, in_empty, in_startofpacket, in_endofpacket}),
    .rdata   (rbeat_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (level_s)
  );

  // Flush freezes both ports for its single cycle
  assign in_ready  = !full_s && !flush_r;
  assign out_valid = !empty_s && !flush_r;
  assign {out_data, out_empty, out_startofpacket, out_endofpacket} = rbeat_s;
  assign accept_s  = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  assign err_clr_s   = csr_write && (csr_address == CSR_ERR_CNT);
  assign flush_set_s = csr_write && (csr_address == CSR_CTRL) && csr_writedata[0];

  // Framing check, write enable and next packet state
  always_comb begin
    orphan_s     = !in_startofpacket && !in_pkt_r;
    err_s        = accept_s && ((in_startofpacket && in_pkt_r) || orphan_s);
`ifdef PKT_FIFO_ERR_DROP_EN
    wr_en_s      = accept_s && !orphan_s;
`else
    wr_en_s      = accept_s;
`endif
    in_pkt_nxt_s = in_pkt_r;
    if (flush_r) begin
      in_pkt_nxt_s = 1'b0;
    end else if (accept_s) begin
      if (in_endofpacket) begin
        in_pkt_nxt_s = 1'b0;
      end else if (in_startofpacket) begin
        in_pkt_nxt_s = 1'b1;
      end else begin
        in_pkt_nxt_s = in_pkt_r;
      end
    end else begin
      in_pkt_nxt_s = in_pkt_r;
    end
  end

  // Packet state and self-clearing flush request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_r <= 1'b0;
      flush_r  <= 1'b0;
    end else begin
      in_pkt_r <= in_pkt_nxt_s;
      flush_r  <= flush_set_s;
    end
  end

  // Forwarded-packet and framing-error counters; a clear still records a coincident error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_r <= 32'd0;
      err_count_r <= 32'd0;
    end else begin
      if (pop_s && out_endofpacket) pkt_count_r <= pkt_count_r + 32'd1;
      if (err_clr_s)   err_count_r <= {31'd0, err_s};
      else if (err_s)  err_count_r <= sat_inc32(err_count_r);
    end
  end

  // CSR read mux
  always_comb begin
    rd_mux_s = 32'd0;
    case (csr_address)
      CSR_LEVEL:   rd_mux_s = 32'(level_s);
      CSR_PKT_CNT: rd_mux_s = pkt_count_r;
      CSR_ERR_CNT: rd_mux_s = err_count_r;
      CSR_CTRL:    rd_mux_s = {31'd0, flush_r};
      default:     rd_mux_s = 32'd0;
    endcase
  end

  // Registered read response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r      <= 32'd0;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= csr_read;
      if (csr_read) readdata_r <= rd_mux_s;
    end
  end

  assign csr_readdata      = readdata_r;
  assign csr_readdatavalid = readdatavalid_r;
  assign csr_waitrequest   = 1'b0;

endmodule

// File: doc/avalon_st_pkt_fifo.md
Name: avalon_st_pkt_fifo

Overview:
Avalon-ST packet FIFO that sits directly downstream of the endian swapper stage. It buffers swapped beats and decouples the swapper from a stalling sink. It checks SOP/EOP framing and exposes fill level, forwarded-packet count, framing-error count and a flush control through a small Avalon-MM CSR bus. Both streams have readyLatency 0; the CSR bus has a fixed readLatency of 1.

Parameters:
DATA_BYTES, 8, stream data width in bytes; empty width is $clog2(DATA_BYTES).
DEPTH, 16, FIFO depth in beats; must be a power of 2 and at least 2.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
in_data  in  DATA_BYTES*8  upstream beat data
in_empty  in  $clog2(DATA_BYTES)  empty bytes; meaningful only on EOP
in_valid  in  1  upstream beat valid
in_startofpacket  in  1  SOP
in_endofpacket  in  1  EOP
in_ready  out  1  FIFO can accept a beat this cycle
out_data  out  DATA_BYTES*8  head beat data
out_empty  out  $clog2(DATA_BYTES)  head beat empty
out_valid  out  1  head beat valid
out_startofpacket  out  1  head SOP
out_endofpacket  out  1  head EOP
out_ready  in  1  downstream accepts
csr_address  in  2  register select
csr_read  in  1  read strobe
csr_write  in  1  write strobe
csr_writedata  in  32  write data
csr_readdata  out  32  read data, valid one cycle after csr_read
csr_readdatavalid  out  1  read data qualifier
csr_waitrequest  out  1  tied 0; all accesses complete immediately

Behaviour:
- Reset: asynchronous on reset_n low, active-low; clock clk. On reset:
  - rd_ptr and wr_ptr = 0, so out_valid = 0 and in_ready = 1 once reset is released.
  - in_pkt = 0, pkt_count = 0, err_count = 0, flush = 0.
  - csr_readdata = 0, csr_readdatavalid = 0.
  - Reset mid-packet discards all stored beats; no partial output is emitted.
- Storage: a DEPTH-entry array of {data, empty, sop, eop}.
  - Pointers are $clog2(DEPTH)+1 bits wide.
  - empty when rd_ptr == wr_ptr; full when the MSBs differ and the lower bits are equal.
  - Level = wr_ptr - rd_ptr, range 0..DEPTH.
- Push: on in_valid & in_ready. in_ready = !full & !flush, combinational.
- Pop: on out_valid & out_ready. out_valid = !empty; out_* are driven from mem[rd_ptr].
- Latency: a beat pushed in cycle N is visible on out_* in cycle N+1. There is no same-cycle bypass.
- Push and pop in the same cycle: both are performed and the level is unchanged.
  - When full, in_ready = 0; a pop in that cycle raises in_ready in the next cycle.
- Framing checker, tracking in_pkt on accepted beats:
  - An SOP beat while in_pkt = 1 is a framing error. The beat is stored and the packet restarts.
  - A non-SOP beat while in_pkt = 0 is a framing error; the beat is stored.
  - An SOP beat sets in_pkt; an EOP beat clears it. An SOP+EOP beat is a single-beat packet.
- err_count: incremented once per erroneous beat; saturates at 0xFFFFFFFF.
- pkt_count: incremented on each popped EOP beat; wraps modulo 2^32.
- CSR map, read data registered one cycle after csr_read:
  - addr 0 [RO]: bits $clog2(DEPTH):0 = level, rest 0.
  - addr 1 [RO]: pkt_count.
  - addr 2 [RO/clear]: err_count; any write clears it.
    - A clear and an error in the same cycle leave err_count = 1.
  - addr 3 [R/W]: bit 0 = flush request, self-clearing.
    - Writing 1 sets flush for exactly one cycle.
    - During that cycle in_ready = 0 and no pop occurs (out_valid is forced to 0).
    - The next edge sets rd_ptr = wr_ptr = 0 and in_pkt = 0. Counters are untouched.
  - csr_readdatavalid pulses for 1 cycle per read.
  - Reads of an unmapped bit return 0.
  - Simultaneous read and write: the read returns the pre-write value.

Optional Feature:
- Macro PKT_FIFO_ERR_DROP_EN.
- When defined: a non-SOP beat arriving while in_pkt = 0 is accepted (in_ready still asserted) but not written to the FIFO. It is still counted in err_count.
- When undefined: all accepted beats are stored, as described above.
- A duplicate SOP is always stored in both builds.

Decomposition:
- Shared package avalon_st_pkg holds:
  - the beat struct typedef {data, empty, sop, eop}, parameterised by DATA_BYTES;
  - CSR address localparams (LEVEL=0, PKT_CNT=1, ERR_CNT=2, CTRL=3);
  - DATA_BYTES default.
- Natural sub-module: sync_fifo_core, covering the storage array, pointers, full/empty and level, with a synchronous clear input.
- Framing checker and CSR logic stay in the top level.

Test Plan:
- Reset, then one 3-beat packet (SOP, mid, EOP, empty=3) with out_ready=1:
  - out beats appear 1 cycle after each push with identical data and flags;
  - addr 1 then reads 1.
- out_ready=0 with 16 pushes (DEPTH 16):
  - in_ready drops after the 16th push; addr 0 reads 16;
  - release out_ready for one pop: in_ready = 1 next cycle and the level reads 15.
- Simultaneous push and pop at level 5 for 10 cycles: level stays 5 and data order is preserved.
- Framing errors: two SOPs without EOP, then a beat without SOP after an EOP:
  - addr 2 reads 2;
  - write addr 2 with 0 in the same cycle as a third error: addr 2 reads 1.
- Flush: 7 beats buffered, write addr 3 = 1:
  - in_ready = 0 and out_valid = 0 for 1 cycle, then the level reads 0 and out_valid = 0;
  - pkt_count is unchanged.
- Build with PKT_FIFO_ERR_DROP_EN: 2 orphan beats are pushed, addr 0 reads 0 and addr 2 reads 2.
  - Without the macro the same stimulus gives addr 0 = 2.
